// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals: pipeline writeback, multi-cycle
// result handshake, issue/decode scoreboard hooks and the Reg_File write port.
interface rf_wb_arbiter_if;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        stall_wb;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  modport master (
    output wb_en, wb_addr, wb_data,
    output mc_valid, mc_addr, mc_data,
    output iss_en, iss_rd, dec_rs1, dec_rs2, dec_rd,
    input  mc_ready, stall_wb, hazard,
    input  rf_w_en, rf_w_addr, rf_w_data
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  mc_valid, mc_addr, mc_data,
    input  iss_en, iss_rd, dec_rs1, dec_rs2, dec_rd,
    output mc_ready, stall_wb, hazard,
    output rf_w_en, rf_w_addr, rf_w_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the Reg_File write port between the pipeline writeback (priority) and the multi-cycle
// result port, forcing a one-cycle grant after MAX_WAIT refusals; tracks pending mc writes.
module rf_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  localparam logic StIdle  = 1'b0;
  localparam logic StForce = 1'b1;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WaitMax  = CNT_W'(MAX_WAIT);

  logic             state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic             stall_wb_q, stall_wb_d;

  logic wb_free;
  logic grant;
  logic xfer;
  logic hazard_raw;

  always_comb begin
    wb_free = !bus.wb_en || (bus.wb_addr == 5'd0);
    grant   = (state_q == StForce) || wb_free;
    xfer    = bus.mc_valid && grant;
  end

  assign bus.mc_ready = grant && !rst;
  assign bus.stall_wb = stall_wb_q;

  // Write port mux; a granted mc result always wins, even when it targets x0 (then discarded).
  always_comb begin
    bus.rf_w_en   = 1'b0;
    bus.rf_w_addr = bus.wb_addr;
    bus.rf_w_data = bus.wb_data;
    if (xfer) begin
      bus.rf_w_en   = (bus.mc_addr != 5'd0);
      bus.rf_w_addr = bus.mc_addr;
      bus.rf_w_data = bus.mc_data;
    end else if (state_q == StIdle) begin
      bus.rf_w_en = bus.wb_en && (bus.wb_addr != 5'd0);
    end
    if (rst) begin
      bus.rf_w_en = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (xfer || !bus.mc_valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.mc_valid && !grant && (wait_cnt_q == WaitLast)) begin
          state_d = StForce;
        end
      end
      StForce: begin
        // A dropped mc_valid here is a protocol violation; leave without writing.
        if (xfer || !bus.mc_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    stall_wb_d = (state_d == StForce);
  end

  // Set is applied after clear so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (bus.mc_addr != 5'd0)) begin
      busy_d[bus.mc_addr] = 1'b0;
    end
    if (bus.iss_en && (bus.iss_rd != 5'd0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    hazard_raw = 1'b0;
    if (bus.dec_rs1 != 5'd0) begin
      hazard_raw = hazard_raw | busy_q[bus.dec_rs1];
    end
    if (bus.dec_rs2 != 5'd0) begin
      hazard_raw = hazard_raw | busy_q[bus.dec_rs2];
    end
    if (bus.dec_rd != 5'd0) begin
      hazard_raw = hazard_raw | busy_q[bus.dec_rd];
    end
  end

  assign bus.hazard = hazard_raw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      busy_q     <= '0;
      stall_wb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      stall_wb_q <= stall_wb_d;
    end
  end

endmodule
